viterbi_acs_sequencer: RTL and testbench
========================================

VITERBI_ACS_SEQUENCER -- requirements
Module: viterbi_acs_sequencer

Interface
REQ-001 Parameter: FRAME_LEN, default 8, symbol pairs per frame (legal 4..64).
REQ-002 CLK  input  1  rising-edge clock.
REQ-003 RST_N  input  1  asynchronous active-low reset.
REQ-004 start  input  1  one-cycle pulse; begins a frame when in IDLE.
REQ-005 busy  output  1  high in every state except IDLE.
REQ-006 in_valid / in_ready  input / output  1 / 1  symbol-pair handshake.
REQ-007 sym_a, sym_b  input  8 / 8  received soft symbols; hard bit = MSB (1 = bit one).
REQ-008 out_valid / out_ready  output / input  1 / 1  decoded-bit handshake.
REQ-009 out_bit  output  1  decoded bit, frame order (symbol 0 first).
REQ-010 out_last  output  1  high with the final decoded bit of the frame.
REQ-011 out_metric  output  8  final path metric of state 00, valid while busy is low after a frame.

Function
REQ-012 Code: rate 1/2, K=3, generators 7/5; state s={s1,s0}; input u gives c0=u^s1^s0, c1=u^s0, next={u,s1}.
REQ-013 FSM: IDLE -start-> ACS -FRAME_LEN pairs accepted-> TRACE -FRAME_LEN cycles-> OUT -last bit accepted-> IDLE.
REQ-014 start outside IDLE is ignored.
REQ-015 On entering ACS: metric[00]=0, metrics of states 01, 10 and 11 = 64; symbol counter = 0.
REQ-016 in_ready is high only in ACS; one pair is consumed per cycle with in_valid&&in_ready.
REQ-017 Branch metric = (c0!=hard_a)+(c1!=hard_b), range 0..2.
REQ-018 Per consumed pair, all 4 states update in the same cycle: new state n={u,n0} picks the predecessor {n0,x} with the smaller metric plus branch metric.
REQ-019 On a tie, the predecessor with x=0 wins.
REQ-020 The decision bit x for each state is written to survivor memory[t][n].
REQ-021 TRACE starts at state 00 (terminated frame), one step per cycle from t=FRAME_LEN-1 down to 0.
REQ-022 Each TRACE step: decoded[t]=n[1], then n={n[0],surv[t][n]}.
REQ-023 OUT streams decoded[0..FRAME_LEN-1]; out_bit/out_last are held stable while out_valid&&!out_ready; out_valid is low outside OUT.
REQ-024 out_metric latches metric[00] at the ACS->TRACE transition.
REQ-025 Path metrics are 8-bit unsigned.

Reset
REQ-026 RST_N low, at any time and mid-frame: FSM->IDLE; busy, in_ready, out_valid, out_bit, out_last = 0; out_metric = 0; counters = 0; survivor memory is not cleared.
REQ-027 A frame aborted by reset produces no output; the next start runs a clean frame.

Configuration
REQ-028 Macro VITERBI_METRIC_NORM_EN defined: after each ACS update, if all 4 new metrics are >=128, subtract 128 from each in the same cycle.
REQ-029 Macro VITERBI_METRIC_NORM_EN undefined: each new metric saturates at 255 and no subtraction occurs.

Structure
REQ-030 Shared package viterbi_pkg holds: the FSM state enum, the generator constants, METRIC_W=8, and the initial metric value 64.
REQ-031 Combinational sub-module viterbi_acs4 computes branch metrics, the four add-compare-selects, decisions and normalization/saturation; the sequencer instantiates it once.

Verification
REQ-032 All-zero symbols, FRAME_LEN=8 -> out_bit stream 0,0,0,0,0,0,0,0; out_last on bit 7; out_metric=0.
REQ-033 Hard pairs (a,b) = 11,10,00,01,01,11,00,00, with 0x80=1 and 0x00=0 -> decoded 1,0,1,1,0,0,0,0; out_metric=0.
REQ-034 Same frame as REQ-033 with the first sym_a flipped to 0x00 -> same decoded bits; out_metric=1.
REQ-035 Out-stream stall: out_ready low for 3 cycles in mid-stream -> out_bit/out_last held unchanged, no bit dropped or repeated; in_valid gaps in ACS -> same result as gap-free input.
REQ-036 RST_N pulsed after 3 accepted pairs, then start and the REQ-033 frame -> REQ-033 response; start pulsed while busy -> no effect.
REQ-037 FRAME_LEN=64 with alternating-error input -> with macro, metrics never exceed 255 and decoding matches the reference model; without macro, saturation at 255 matches the model.

Source files
------------

// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - shared FSM states, code generators and metric constants
package viterbi_pkg;

  localparam int METRIC_W = 8;
  localparam logic [METRIC_W-1:0] METRIC_INIT = 8'd64;

  // Generator taps over the shift register {u, s1, s0}: 7 -> c0, 5 -> c1
  localparam logic [2:0] GEN_C0 = 3'b111;
  localparam logic [2:0] GEN_C1 = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACS,
    ST_TRACE,
    ST_OUT
  } state_t;

  typedef logic [METRIC_W-1:0] metric_t;

  // Encoder output {c0, c1} for input u leaving state s = {s1, s0}
  function automatic logic [1:0] encode(input logic u, input logic [1:0] s);
    logic [2:0] taps;
    taps = {u, s};
    return {^(taps & GEN_C0), ^(taps & GEN_C1)};
  endfunction

endpackage

// File: rtl/viterbi_acs_sequencer_if.sv
// rtl/viterbi_acs_sequencer_if.sv - control, symbol and decoded-bit handshakes of the sequencer
interface viterbi_acs_sequencer_if;
  import viterbi_pkg::*;

  logic    start;
  logic    busy;
  logic    in_valid;
  logic    in_ready;
  logic [7:0] sym_a;
  logic [7:0] sym_b;
  logic    out_valid;
  logic    out_ready;
  logic    out_bit;
  logic    out_last;
  metric_t out_metric;

  modport master (
    output start, in_valid, sym_a, sym_b, out_ready,
    input  busy, in_ready, out_valid, out_bit, out_last, out_metric
  );

  modport slave (
    input  start, in_valid, sym_a, sym_b, out_ready,
    output busy, in_ready, out_valid, out_bit, out_last, out_metric
  );

endinterface

// File: rtl/viterbi_acs4.sv
// rtl/viterbi_acs4.sv - four-state add-compare-select; VITERBI_METRIC_NORM_EN selects normalization over saturation
module viterbi_acs4
  import viterbi_pkg::*;
(
  input  logic [3:0][METRIC_W-1:0] metric_in,
  input  logic                     hard_a,
  input  logic                     hard_b,
  output logic [3:0][METRIC_W-1:0] metric_out,
  output logic [3:0]               decision
);

  logic [3:0][METRIC_W:0] cand0;
  logic [3:0][METRIC_W:0] cand1;
  logic [3:0][METRIC_W:0] survivor_sum;

  // Hamming distance between the expected code pair and the received hard bits
  function automatic logic [1:0] branch_metric(input logic u, input logic [1:0] pred,
                                               input logic ha, input logic hb);
    logic [1:0] code;
    code = encode(u, pred);
    return {1'b0, code[1] ^ ha} + {1'b0, code[0] ^ hb};
  endfunction

  // Clamp a widened metric back into the 8-bit range
  function automatic metric_t sat_metric(input logic [METRIC_W:0] value);
    return value[METRIC_W] ? {METRIC_W{1'b1}} : value[METRIC_W-1:0];
  endfunction

  // Next state n = {u, n0} chooses between predecessors {n0,0} and {n0,1}; ties keep x = 0
  always_comb begin
    cand0        = '0;
    cand1        = '0;
    survivor_sum = '0;
    decision     = '0;
    for (int n = 0; n < 4; n++) begin
      cand0[n] = {1'b0, metric_in[{n[0], 1'b0}]}
               + {{(METRIC_W-1){1'b0}}, branch_metric(n[1], {n[0], 1'b0}, hard_a, hard_b)};
      cand1[n] = {1'b0, metric_in[{n[0], 1'b1}]}
               + {{(METRIC_W-1){1'b0}}, branch_metric(n[1], {n[0], 1'b1}, hard_a, hard_b)};
      decision[n]     = (cand1[n] < cand0[n]);
      survivor_sum[n] = decision[n] ? cand1[n] : cand0[n];
    end
  end

`ifdef VITERBI_METRIC_NORM_EN
  logic all_high;

  // Rebase all metrics by 128 once every state has climbed past it
  always_comb begin
    all_high   = 1'b1;
    metric_out = '0;
    for (int n = 0; n < 4; n++) begin
      if (survivor_sum[n] < 9'd128) all_high = 1'b0;
    end
    for (int n = 0; n < 4; n++) begin
      // Saturation here is only a guard; rebased metrics stay far below 255
      metric_out[n] = sat_metric(all_high ? survivor_sum[n] - 9'd128 : survivor_sum[n]);
    end
  end
`else
  // Plain saturating metrics
  always_comb begin
    metric_out = '0;
    for (int n = 0; n < 4; n++) begin
      metric_out[n] = sat_metric(survivor_sum[n]);
    end
  end
`endif

endmodule

// File: rtl/viterbi_acs_sequencer.sv
// rtl/viterbi_acs_sequencer.sv - frame sequencer: ACS over FRAME_LEN pairs, traceback, decoded-bit stream
module viterbi_acs_sequencer
  import viterbi_pkg::*;
#(
  parameter int FRAME_LEN = 8
) (
  input  logic CLK,
  input  logic RST_N,
  viterbi_acs_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  state_t state;
  state_t state_next;

  logic [CNT_W-1:0]          sym_cnt;
  logic [CNT_W-1:0]          trace_cnt;
  logic [CNT_W-1:0]          out_cnt;
  logic [3:0][METRIC_W-1:0]  metric;
  logic [3:0][METRIC_W-1:0]  metric_new;
  logic [3:0]                decision;
  logic [FRAME_LEN-1:0][3:0] surv;
  logic [FRAME_LEN-1:0]      decoded;
  logic [1:0]                trace_state;
  metric_t                   out_metric_q;
  logic                      in_fire;
  logic                      out_fire;
  logic                      busy_c;
  logic                      in_ready_c;
  logic                      out_valid_c;

  viterbi_acs4 u_acs4 (
    .metric_in  (metric),
    .hard_a     (bus.sym_a[7]),
    .hard_b     (bus.sym_b[7]),
    .metric_out (metric_new),
    .decision   (decision)
  );

  assign in_fire  = (state == ST_ACS) && bus.in_valid;
  assign out_fire = (state == ST_OUT) && bus.out_ready;

  // FSM state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state decode and handshake outputs
  always_comb begin
    state_next  = state;
    busy_c      = 1'b1;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state)
      ST_IDLE: begin
        busy_c = 1'b0;
        if (bus.start) state_next = ST_ACS;
      end
      ST_ACS: begin
        in_ready_c = 1'b1;
        if (in_fire && sym_cnt == LAST_IDX) state_next = ST_TRACE;
      end
      ST_TRACE: begin
        if (trace_cnt == '0) state_next = ST_OUT;
      end
      ST_OUT: begin
        out_valid_c = 1'b1;
        if (out_fire && out_cnt == LAST_IDX) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Survivor decisions are deliberately left uninitialised across reset
  always_ff @(posedge CLK) begin
    if (in_fire) surv[sym_cnt] <= decision;
  end

  // Metrics, counters, traceback walk and decoded-bit buffer
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      metric       <= '0;
      sym_cnt      <= '0;
      trace_cnt    <= '0;
      out_cnt      <= '0;
      trace_state  <= '0;
      decoded      <= '0;
      out_metric_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            metric  <= {METRIC_INIT, METRIC_INIT, METRIC_INIT, {METRIC_W{1'b0}}};
            sym_cnt <= '0;
          end
        end
        ST_ACS: begin
          if (in_fire) begin
            metric <= metric_new;
            if (sym_cnt == LAST_IDX) begin
              sym_cnt      <= '0;
              out_metric_q <= metric_new[0];
              trace_cnt    <= LAST_IDX;
              trace_state  <= 2'b00;
            end else begin
              sym_cnt <= sym_cnt + 1'b1;
            end
          end
        end
        ST_TRACE: begin
          // Walk back to the predecessor {n0, x}; the input bit of step t is n[1]
          decoded[trace_cnt] <= trace_state[1];
          trace_state        <= {trace_state[0], surv[trace_cnt][trace_state]};
          if (trace_cnt == '0) out_cnt   <= '0;
          else                 trace_cnt <= trace_cnt - 1'b1;
        end
        ST_OUT: begin
          if (out_fire) begin
            if (out_cnt == LAST_IDX) out_cnt <= '0;
            else                     out_cnt <= out_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = busy_c;
  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = out_valid_c;
  assign bus.out_bit    = out_valid_c && decoded[out_cnt];
  assign bus.out_last   = out_valid_c && (out_cnt == LAST_IDX);
  assign bus.out_metric = out_metric_q;

endmodule

// File: tb/tb_viterbi_acs_sequencer.sv
// tb/tb_viterbi_acs_sequencer.sv - scoreboard bench for 8- and 64-pair sequencer instances
module tb_viterbi_acs_sequencer;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  viterbi_acs_sequencer_if if8 ();
  viterbi_acs_sequencer_if if64 ();

  logic       start8 = 1'b0;
  logic       start64 = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] sym_a = 8'h00;
  logic [7:0] sym_b = 8'h00;
  bit         big = 1'b0;

  assign if8.start      = start8;
  assign if64.start     = start64;
  assign if8.in_valid   = in_valid;
  assign if64.in_valid  = in_valid;
  assign if8.sym_a      = sym_a;
  assign if64.sym_a     = sym_a;
  assign if8.sym_b      = sym_b;
  assign if64.sym_b     = sym_b;
  assign if8.out_ready  = out_ready;
  assign if64.out_ready = out_ready;

  viterbi_acs_sequencer #(.FRAME_LEN(8)) dut8 (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (if8.slave)
  );

  viterbi_acs_sequencer #(.FRAME_LEN(64)) dut64 (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (if64.slave)
  );

  logic       obs_busy, obs_in_ready, obs_out_valid, obs_out_bit, obs_out_last;
  logic [7:0] obs_out_metric;
  assign obs_busy       = big ? if64.busy       : if8.busy;
  assign obs_in_ready   = big ? if64.in_ready   : if8.in_ready;
  assign obs_out_valid  = big ? if64.out_valid  : if8.out_valid;
  assign obs_out_bit    = big ? if64.out_bit    : if8.out_bit;
  assign obs_out_last   = big ? if64.out_last   : if8.out_last;
  assign obs_out_metric = big ? if64.out_metric : if8.out_metric;

  int checks = 0;
  int errors = 0;

  bit         exp_q[$];
  logic [7:0] fa[64];
  logic [7:0] fb[64];
  bit         model_bits[64];
  int         model_metric;

  // Independent soft-decision-free Viterbi reference over fa/fb
  task automatic ref_model(input int n);
    int m[4];
    int nm[4];
    bit sv[64][4];
    int st;
    m = '{0, 64, 64, 64};
    for (int t = 0; t < n; t++) begin
      int ha, hb;
      ha = fa[t][7];
      hb = fb[t][7];
      for (int ns = 0; ns < 4; ns++) begin
        int u, n0, best;
        u = ns >> 1;
        n0 = ns & 1;
        best = 0;
        for (int x = 0; x < 2; x++) begin
          int p, c0, c1, cand;
          p = n0 * 2 + x;
          c0 = u ^ (p >> 1) ^ (p & 1);
          c1 = u ^ (p & 1);
          cand = m[p] + ((c0 != ha) ? 1 : 0) + ((c1 != hb) ? 1 : 0);
          if (x == 0 || cand < best) begin
            best = cand;
            sv[t][ns] = x[0];
          end
        end
        nm[ns] = best;
      end
`ifdef VITERBI_METRIC_NORM_EN
      if (nm[0] >= 128 && nm[1] >= 128 && nm[2] >= 128 && nm[3] >= 128)
        for (int i = 0; i < 4; i++) nm[i] = nm[i] - 128;
`else
      for (int i = 0; i < 4; i++) if (nm[i] > 255) nm[i] = 255;
`endif
      m = nm;
    end
    st = 0;
    for (int t = n - 1; t >= 0; t--) begin
      model_bits[t] = st[1];
      st = ((st & 1) << 1) | int'(sv[t][st]);
    end
    model_metric = m[0];
  endtask

  task automatic load_known_frame();
    logic [7:0] abits;
    logic [7:0] bbits;
    abits = 8'b11000100;
    bbits = 8'b10011100;
    for (int t = 0; t < 8; t++) begin
      fa[t] = abits[7 - t] ? 8'h80 : 8'h00;
      fb[t] = bbits[7 - t] ? 8'h80 : 8'h00;
    end
  endtask

  task automatic push_known_bits();
    logic [7:0] dbits;
    dbits = 8'b10110000;
    for (int t = 0; t < 8; t++) exp_q.push_back(dbits[7 - t]);
  endtask

  task automatic pulse_start();
    @(negedge CLK);
    if (big) start64 = 1'b1;
    else     start8 = 1'b1;
    @(negedge CLK);
    start8 = 1'b0;
    start64 = 1'b0;
  endtask

  // Offers pairs from fa/fb until n have been accepted; optional random gaps and a stray start
  task automatic send_pairs(input int n, input bit gaps, input bit poke_start);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 1000) begin
      guard++;
      start8 = 1'b0;
      start64 = 1'b0;
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        sym_a = 8'($urandom);
        sym_b = 8'($urandom);
      end else begin
        in_valid = 1'b1;
        sym_a = fa[i];
        sym_b = fb[i];
        if (poke_start && i == 4) begin
          start8 = 1'b1;
          start64 = 1'b1;
        end
        if (obs_in_ready) i++;
      end
      @(negedge CLK);
    end
    in_valid = 1'b0;
    start8 = 1'b0;
    start64 = 1'b0;
    if (guard >= 1000) begin
      errors++;
      $display("FAIL send_timeout accepted %0d want %0d", i, n);
    end
  endtask

  // Drains the decoded stream against the scoreboard; optional 3-cycle stall before bit stall_at
  task automatic collect(input int n, input int stall_at, input int exp_metric, input string name);
    int k = 0;
    int guard = 0;
    int stall = 0;
    logic held_bit = 1'b0;
    logic held_last = 1'b0;
    bit   exp_bit;
    while (k < n && guard < 400) begin
      @(negedge CLK);
      guard++;
      if (k == stall_at && stall < 3 && obs_out_valid) begin
        out_ready = 1'b0;
        if (stall == 0) begin
          held_bit = obs_out_bit;
          held_last = obs_out_last;
        end else begin
          checks++;
          if ({obs_out_valid, obs_out_bit, obs_out_last} !== {1'b1, held_bit, held_last}) begin
            errors++;
            $display("FAIL %s_stall_hold got v%b b%b l%b want v1 b%b l%b", name,
                     obs_out_valid, obs_out_bit, obs_out_last, held_bit, held_last);
          end
        end
        stall++;
      end else begin
        out_ready = 1'b1;
        if (obs_out_valid) begin
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_extra_bit got bit %0d with empty scoreboard", name, k);
            exp_bit = 1'b0;
          end else begin
            exp_bit = exp_q.pop_front();
          end
          checks++;
          if (obs_out_bit !== exp_bit) begin
            errors++;
            $display("FAIL %s_bit%0d got %b want %b", name, k, obs_out_bit, exp_bit);
          end
          checks++;
          if (obs_out_last !== (k == n - 1)) begin
            errors++;
            $display("FAIL %s_last%0d got %b want %b", name, k, obs_out_last, (k == n - 1));
          end
          k++;
        end
      end
    end
    if (k < n) begin
      errors++;
      $display("FAIL %s_out_timeout got %0d bits want %0d", name, k, n);
    end
    @(negedge CLK);
    out_ready = 1'b0;
    checks++;
    if ({obs_busy, obs_out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL %s_idle got busy%b valid%b want 00", name, obs_busy, obs_out_valid);
    end
    checks++;
    if (obs_out_metric !== 8'(exp_metric)) begin
      errors++;
      $display("FAIL %s_metric got %0d want %0d", name, obs_out_metric, exp_metric);
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    for (int d = 0; d < 2; d++) begin
      big = d[0];
      #1;
      checks++;
      if ({obs_busy, obs_in_ready, obs_out_valid, obs_out_bit, obs_out_last} !== 5'b0) begin
        errors++;
        $display("FAIL reset_flags dut%0d got %b%b%b%b%b want 00000", d, obs_busy,
                 obs_in_ready, obs_out_valid, obs_out_bit, obs_out_last);
      end
      checks++;
      if (obs_out_metric !== 8'd0) begin
        errors++;
        $display("FAIL reset_metric dut%0d got %0d want 0", d, obs_out_metric);
      end
    end
    big = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_all_zero();
    big = 1'b0;
    for (int t = 0; t < 8; t++) begin
      fa[t] = 8'h00;
      fb[t] = 8'h00;
      exp_q.push_back(1'b0);
    end
    pulse_start();
    checks++;
    if ({obs_busy, obs_in_ready, obs_out_valid} !== 3'b110) begin
      errors++;
      $display("FAIL acs_entry got busy%b ready%b valid%b want 110", obs_busy, obs_in_ready, obs_out_valid);
    end
    send_pairs(8, 1'b0, 1'b0);
    collect(8, -1, 0, "zero");
  endtask

  task automatic test_known_frame();
    big = 1'b0;
    load_known_frame();
    push_known_bits();
    pulse_start();
    send_pairs(8, 1'b0, 1'b0);
    collect(8, -1, 0, "known");
  endtask

  task automatic test_single_error();
    big = 1'b0;
    load_known_frame();
    fa[0] = 8'h00;
    push_known_bits();
    pulse_start();
    send_pairs(8, 1'b0, 1'b0);
    collect(8, -1, 1, "one_err");
  endtask

  task automatic test_stall_gaps();
    big = 1'b0;
    load_known_frame();
    fa[0] = 8'h00;
    push_known_bits();
    pulse_start();
    send_pairs(8, 1'b1, 1'b1);
    collect(8, 3, 1, "stall_gap");
  endtask

  task automatic test_reset_abort();
    big = 1'b0;
    load_known_frame();
    fa[1] = 8'h80;
    pulse_start();
    send_pairs(3, 1'b0, 1'b0);
    RST_N = 1'b0;
    @(negedge CLK);
    checks++;
    if ({obs_busy, obs_in_ready, obs_out_valid, obs_out_metric} !== 11'd0) begin
      errors++;
      $display("FAIL abort_reset got busy%b ready%b valid%b metric%0d want all 0",
               obs_busy, obs_in_ready, obs_out_valid, obs_out_metric);
    end
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if ({obs_busy, obs_out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL abort_no_output got busy%b valid%b want 00", obs_busy, obs_out_valid);
    end
    load_known_frame();
    push_known_bits();
    pulse_start();
    send_pairs(8, 1'b0, 1'b0);
    collect(8, -1, 0, "after_abort");
  endtask

  // 64-pair terminated frame with errors on alternating symbols, checked against the reference
  task automatic test_long_frame(input bit dense, input string name);
    int s = 0;
    big = 1'b1;
    for (int t = 0; t < 64; t++) begin
      int u, c0, c1, ea, eb;
      u = (t >= 62) ? 0 : int'($urandom_range(0, 1));
      c0 = u ^ (s >> 1) ^ (s & 1);
      c1 = u ^ (s & 1);
      s = (u << 1) | (s >> 1);
      ea = (t % 2 == 0) ? 1 : 0;
      eb = (dense && t % 2 == 1) ? 1 : 0;
      fa[t] = ((c0 ^ ea) != 0) ? 8'hC3 : 8'h3C;
      fb[t] = ((c1 ^ eb) != 0) ? 8'hA5 : 8'h5A;
    end
    ref_model(64);
    for (int t = 0; t < 64; t++) exp_q.push_back(model_bits[t]);
    pulse_start();
    send_pairs(64, 1'b1, 1'b0);
    collect(64, 20, model_metric, name);
    big = 1'b0;
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_known_frame();
    test_single_error();
    test_stall_gaps();
    test_reset_abort();
    test_long_frame(1'b0, "long_sparse");
    test_long_frame(1'b1, "long_dense");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
